// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, FSM states, flag bit positions.
package alu_share_ctrl_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_MULT  = 6'b000010;
  localparam logic [5:0] OP_MULTU = 6'b000011;
  localparam logic [5:0] OP_COMPI = 6'b000101;
  localparam logic [5:0] OP_AND   = 6'b000110;
  localparam logic [5:0] OP_SHRL  = 6'b001001;
  localparam logic [5:0] OP_SHRA  = 6'b001100;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StRespLo,
    StRespHi
  } state_e;

  localparam int unsigned FlagCarry = 3;
  localparam int unsigned FlagZero  = 2;
  localparam int unsigned FlagSign  = 1;
  localparam int unsigned FlagOvf   = 0;

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant; the pointer toggles on each completed operation.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       done_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    ptr_d = ptr_q ^ done_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; holds operands for a settle time,
// then returns a tagged one- or two-beat response.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [5:0]  req0_opcode_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [5:0]  req1_opcode_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_last_o,
  output logic [3:0]  rsp_flags_o,
  output logic [31:0] alu_inp1_o,
  output logic [31:0] alu_inp2_o,
  output logic [5:0]  alu_opcode_o,
  input  logic [31:0] alu_out_i,
  input  logic [63:0] alu_mulout_i,
  input  logic        alu_carry_i,
  input  logic        alu_zero_i,
  input  logic        alu_sign_i,
  input  logic        alu_ovf_i
);

  localparam int unsigned CntW = 8;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [5:0]        opcode_q, opcode_d;
  logic [31:0]       inp1_q, inp1_d, inp2_q, inp2_d;
  logic              id_q, id_d;
  logic [31:0]       data_q, data_d, hi_q, hi_d;
  logic [3:0]        flags_q, flags_d;
  logic [1:0]        gnt;
  logic              done;

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  ({req1_valid_i, req0_valid_i}),
    .done_i (done),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opcode_d     = opcode_q;
    inp1_d       = inp1_q;
    inp2_d       = inp2_q;
    id_d         = id_q;
    data_d       = data_q;
    hi_d         = hi_q;
    flags_d      = flags_q;
    done         = 1'b0;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_last_o   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req0_ready_o = gnt[0];
        req1_ready_o = gnt[1];
        if (gnt != 2'b00) begin
          opcode_d = gnt[1] ? req1_opcode_i : req0_opcode_i;
          inp1_d   = gnt[1] ? req1_a_i : req0_a_i;
          inp2_d   = gnt[1] ? req1_b_i : req0_b_i;
          id_d     = gnt[1];
          cnt_d    = is_mul_op(opcode_d) ? CntW'(MUL_LAT) : CntW'(ALU_LAT);
          state_d  = StExec;
        end
      end
      StExec: begin
        if (cnt_q == CntW'(1)) begin
          data_d  = is_mul_op(opcode_q) ? alu_mulout_i[31:0] : alu_out_i;
          hi_d    = alu_mulout_i[63:32];
          flags_d = {alu_carry_i, alu_zero_i, alu_sign_i, alu_ovf_i};
          state_d = is_mul_op(opcode_q) ? StRespLo : StRespHi;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StRespLo: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          data_d  = hi_q;
          state_d = StRespHi;
        end
      end
      StRespHi: begin
        rsp_valid_o = 1'b1;
        rsp_last_o  = 1'b1;
        if (rsp_ready_i) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      opcode_q <= '0;
      inp1_q   <= '0;
      inp2_q   <= '0;
      id_q     <= 1'b0;
      data_q   <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      inp1_q   <= inp1_d;
      inp2_q   <= inp2_d;
      id_q     <= id_d;
      data_q   <= data_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
    end
  end

  assign rsp_id_o     = id_q;
  assign rsp_data_o   = data_q;
  assign rsp_flags_o  = flags_q;
  assign alu_inp1_o   = inp1_q;
  assign alu_inp2_o   = inp2_q;
  assign alu_opcode_o = opcode_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU, vector table, directed corner cases, random traffic.
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  localparam int unsigned ALU_LAT = 1;
  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_opcode, req1_opcode, alu_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_last;
  logic [31:0] rsp_data, alu_inp1, alu_inp2, alu_out;
  logic [3:0]  rsp_flags;
  logic [63:0] alu_mulout;
  logic        alu_carry, alu_zero, alu_sign, alu_ovf;

  int n_chk = 0;
  int n_pass = 0;
  bit ptr_m = 1'b0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_opcode_i(req0_opcode),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_opcode_i(req1_opcode),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_last_o(rsp_last), .rsp_flags_o(rsp_flags),
    .alu_inp1_o(alu_inp1), .alu_inp2_o(alu_inp2), .alu_opcode_o(alu_opcode),
    .alu_out_i(alu_out), .alu_mulout_i(alu_mulout),
    .alu_carry_i(alu_carry), .alu_zero_i(alu_zero), .alu_sign_i(alu_sign), .alu_ovf_i(alu_ovf)
  );

  // Stand-in ALU; mult's 32-bit output deliberately differs from the product low word.
  function automatic logic [31:0] f_res(input logic [5:0] op, input logic [31:0] a, b);
    case (op)
      OP_ADD, OP_ADDI:   return a + b;
      OP_AND:            return a & b;
      OP_SHRL:           return a >> b[4:0];
      OP_SHRA:           return 32'($signed(a) >>> b[4:0]);
      OP_COMPI:          return ~a;
      OP_MULT, OP_MULTU: return 32'h5A5A_0000 ^ b;
      default:           return a ^ b;
    endcase
  endfunction

  function automatic logic [63:0] f_mul(input logic [5:0] op, input logic [31:0] a, b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return {32'd0, a} * {32'd0, b};
      default:  return 64'h0123_4567_89AB_CDEF ^ {a, b};
    endcase
  endfunction

  function automatic logic [3:0] f_flags(input logic [5:0] op, input logic [31:0] a, b);
    logic [32:0] s;
    logic [31:0] r;
    logic        is_add;
    s      = {1'b0, a} + {1'b0, b};
    r      = f_res(op, a, b);
    is_add = (op == OP_ADD) || (op == OP_ADDI);
    return {is_add & s[32], r == 32'd0, r[31],
            is_add & (a[31] == b[31]) & (r[31] != a[31])};
  endfunction

  always_comb begin
    alu_out    = f_res(alu_opcode, alu_inp1, alu_inp2);
    alu_mulout = f_mul(alu_opcode, alu_inp1, alu_inp2);
    {alu_carry, alu_zero, alu_sign, alu_ovf} = f_flags(alu_opcode, alu_inp1, alu_inp2);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Raise the valids at the current negedge; returns at the negedge after the accept edge.
  task automatic issue(input bit v0, v1, input logic [5:0] op0, input logic [31:0] a0, b0,
                       input logic [5:0] op1, input logic [31:0] a1, b1, output bit gid);
    int n;
    req0_opcode = op0; req0_a = a0; req0_b = b0;
    req1_opcode = op1; req1_a = a1; req1_b = b1;
    req0_valid  = v0;  req1_valid = v1;
    gid = (v0 && v1) ? ptr_m : v1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("grant_req0_ready", 64'(req0_ready), 64'(!gid));
    chk("grant_req1_ready", 64'(req1_ready), 64'(gid));
    @(negedge clk);
    if (gid) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
  endtask

  task automatic collect(input bit id, input logic [5:0] op, input logic [31:0] a, b,
                         input logic [31:0] lo, hi, input bit two, input int stall);
    int k, lat;
    bit sv0, sv1;
    logic [3:0]  fl;
    logic [31:0] exp_d;
    k   = 1;
    lat = int'(two ? MUL_LAT : ALU_LAT) + 1;
    fl  = f_flags(op, a, b);
    while (!rsp_valid && k < 50) begin
      @(negedge clk); k++;
    end
    chk("rsp_latency", 64'(k), 64'(lat));
    for (int bt = 0; bt < (two ? 2 : 1); bt++) begin
      exp_d = (bt == 0) ? lo : hi;
      chk("rsp_valid", 64'(rsp_valid), 64'(1));
      chk("rsp_data", 64'(rsp_data), 64'(exp_d));
      chk("rsp_last", 64'(rsp_last), 64'(!two || bt == 1));
      chk("rsp_id", 64'(rsp_id), 64'(id));
      chk("rsp_flags", 64'(rsp_flags), 64'(fl));
      if (stall > 0 && bt == 0) begin
        sv0 = req0_valid; sv1 = req1_valid;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (stall) begin
          @(negedge clk);
          chk("hold_valid", 64'(rsp_valid), 64'(1));
          chk("hold_data", 64'(rsp_data), 64'(exp_d));
          chk("hold_last", 64'(rsp_last), 64'(!two));
          chk("hold_id", 64'(rsp_id), 64'(id));
          chk("hold_flags", 64'(rsp_flags), 64'(fl));
          chk("hold_ready", 64'({req0_ready, req1_ready}), 64'(0));
        end
        req0_valid = sv0; req1_valid = sv1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    ptr_m ^= 1'b1;
    chk("rsp_idle", 64'(rsp_valid), 64'(0));
  endtask

  typedef struct {
    bit          id;
    logic [5:0]  op;
    logic [31:0] a, b, lo, hi;
    bit          two;
    int          stall;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [5:0]  ops[9];
    bit          gid, v0, v1, two;
    logic [5:0]  op0, op1, op;
    logic [31:0] a0, b0, a1, b1, a, b, lo, hi;
    logic [63:0] m;

    vecs[0] = '{1'b0, OP_ADD,   32'h0000_008B, 32'hFFFF_FFFF, 32'h0000_008A, 32'h0, 1'b0, 0};
    vecs[1] = '{1'b1, OP_MULT,  32'h0000_0078, 32'hFFFF_FFF6, 32'hFFFF_FB50, 32'hFFFF_FFFF,
                1'b1, 0};
    vecs[2] = '{1'b0, OP_MULTU, 32'h0000_0078, 32'hFFFF_FFF6, 32'hFFFF_FB50, 32'h0000_0077,
                1'b1, 0};
    vecs[3] = '{1'b1, OP_MULT,  32'h0000_0078, 32'hFFFF_FFF6, 32'hFFFF_FB50, 32'hFFFF_FFFF,
                1'b1, 5};
    vecs[4] = '{1'b0, 6'b111111, 32'h0000_1234, 32'h0000_FFFF, 32'h0000_EDCB, 32'h0, 1'b0, 2};
    vecs[5] = '{1'b1, OP_SHRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 32'h0, 1'b0, 0};
    ops = '{OP_ADD, OP_ADDI, OP_MULT, OP_MULTU, OP_COMPI, OP_AND, OP_SHRL, OP_SHRA, 6'b101010};

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_opcode = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_ready", 64'({req0_ready, req1_ready}), 64'(0));
    chk("reset_alu_regs", {alu_opcode, alu_inp1, alu_inp2[25:0]}, 64'(0));
    rst_n = 1'b1;

    // Contention straight out of reset, then a second simultaneous pair.
    issue(1, 1, OP_SHRA, 32'hFC7E_381C, 32'd3, OP_AND, 32'h7FFE_07FF, 32'h7FFF_FFFF, gid);
    chk("contend_first_is_req0", 64'(gid), 64'(0));
    collect(0, OP_SHRA, 32'hFC7E_381C, 32'd3, 32'hFF8F_C703, 32'h0, 1'b0, 0);
    issue(0, 1, OP_SHRA, 32'hFC7E_381C, 32'd3, OP_AND, 32'h7FFE_07FF, 32'h7FFF_FFFF, gid);
    collect(1, OP_AND, 32'h7FFE_07FF, 32'h7FFF_FFFF, 32'h7FFE_07FF, 32'h0, 1'b0, 0);
    issue(1, 1, OP_ADD, 32'd10, 32'd20, OP_ADDI, 32'd1, 32'd2, gid);
    chk("contend_third_is_req0", 64'(req0_valid), 64'(0));
    collect(0, OP_ADD, 32'd10, 32'd20, 32'd30, 32'h0, 1'b0, 0);
    issue(0, 1, OP_ADD, 32'd10, 32'd20, OP_ADDI, 32'd1, 32'd2, gid);
    collect(1, OP_ADDI, 32'd1, 32'd2, 32'd3, 32'h0, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      issue(!vecs[i].id, vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].op, vecs[i].a, vecs[i].b, gid);
      collect(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi,
              vecs[i].two, vecs[i].stall);
    end

    for (int i = 0; i < 30; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      op0 = ops[$urandom_range(0, 8)]; a0 = $urandom; b0 = $urandom;
      op1 = ops[$urandom_range(0, 8)]; a1 = $urandom; b1 = $urandom;
      issue(v0, v1, op0, a0, b0, op1, a1, b1, gid);
      op  = gid ? op1 : op0;
      a   = gid ? a1 : a0;
      b   = gid ? b1 : b0;
      two = (op == OP_MULT) || (op == OP_MULTU);
      m   = f_mul(op, a, b);
      lo  = two ? m[31:0] : f_res(op, a, b);
      hi  = m[63:32];
      collect(gid, op, a, b, lo, hi, two, $urandom_range(0, 2));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset in the middle of a multiply, with the pointer favouring requester 1.
    if (ptr_m == 1'b0) begin
      issue(0, 1, OP_ADD, 32'd0, 32'd0, OP_ADD, 32'd4, 32'd5, gid);
      collect(1, OP_ADD, 32'd4, 32'd5, 32'd9, 32'h0, 1'b0, 0);
    end
    issue(1, 0, OP_MULT, 32'h1234_5678, 32'h9, OP_ADD, 32'd0, 32'd0, gid);
    chk("pre_reset_exec_busy", 64'(alu_opcode), 64'(OP_MULT));
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp", 64'({rsp_valid, rsp_id, rsp_last, rsp_flags}), 64'(0));
    chk("midrst_data", 64'(rsp_data), 64'(0));
    chk("midrst_alu", {alu_opcode, alu_inp1, alu_inp2[25:0]}, 64'(0));
    chk("midrst_ready", 64'({req0_ready, req1_ready}), 64'(0));
    ptr_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_reset_no_rsp", 64'(rsp_valid), 64'(0));
    end
    issue(1, 1, OP_ADDI, 32'd5, 32'd7, OP_AND, 32'hF0, 32'h3C, gid);
    chk("post_reset_first_req0", 64'(gid), 64'(0));
    collect(0, OP_ADDI, 32'd5, 32'd7, 32'd12, 32'h0, 1'b0, 0);
    req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
